shift_sub_divider: RTL and testbench

Sequential sign-magnitude divider: the inverse of the team's 8x8 shift-and-add multiplier. It takes a 16-bit sign-magnitude dividend, in the multiplier's product format, and an 8-bit sign-magnitude divisor. It produces an 8-bit quotient and an 8-bit remainder by restoring shift-and-subtract, one quotient bit per clock. It sits beside the multiplier in the arithmetic datapath, with an explicit start/busy/done handshake.

---
 rtl/shift_sub_divider_pkg.sv | 29 ++
 rtl/shift_sub_divider_sub_compare.sv | 14 +
 rtl/shift_sub_divider.sv | 141 ++++++++++++++
 tb/tb_shift_sub_divider.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sub_divider_pkg.sv
// Shared sign-magnitude arithmetic definitions.
// FSM encoding, width helpers and zero-sign normalisation.
package shift_sub_divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int mag_width(input int w);
    return w - 1;
  endfunction

  function automatic int iter_count(input int w);
    return w - 1;
  endfunction

  // A zero magnitude never carries a negative sign.
  function automatic logic sm_sign(
    input logic sign,
    input logic nonzero
  );
    return sign & nonzero;
  endfunction

endpackage

// File: rtl/shift_sub_divider_sub_compare.sv
// Subtractor for the divider: a - b with borrow out.
// Ports: a, b operands; diff difference; borrow=1 when a < b.
module shift_sub_divider_sub_compare #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  assign {borrow, diff} = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/shift_sub_divider.sv
// Restoring sign-magnitude divider, one quotient bit per clock.
// Ports: clk, nrst, start, Z/W in; Q, R, busy, done, err out.
module shift_sub_divider
  import shift_sub_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] Z,
  input  logic [WIDTH-1:0]   W,
  output logic [WIDTH-1:0]   Q,
  output logic [WIDTH-1:0]   R,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int MW = mag_width(WIDTH);
  localparam int NI = iter_count(WIDTH);
  localparam logic [MW-1:0] LAST = MW'(NI - 1);

  state_t state, state_n;

  logic [MW-1:0] p;
  logic [MW-1:0] zlo;
  logic [MW-1:0] wmag;
  logic [MW-1:0] qw;
  logic [MW-1:0] cnt;
  logic          sq;
  logic          sr;

  logic [WIDTH-1:0] z_hi;
  logic [MW-1:0]    w_in;
  logic             div0;
  logic             ovf;
  logic             bad;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] pp;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic [WIDTH-1:0] p_nx;
  logic [MW-1:0]    q_nx;
  logic             unused_msb;

  assign z_hi   = Z[2*WIDTH-2 -: WIDTH];
  assign w_in   = W[WIDTH-2:0];
  assign div0   = (w_in == '0);
  // High dividend half >= divisor means quotient needs more than MW bits.
  assign ovf    = (z_hi >= {1'b0, w_in});
  assign bad    = div0 | ovf;
  assign accept = (state == IDLE) && start;
  assign last   = (cnt == LAST);

  assign pp = {p, zlo[MW-1]};

  shift_sub_divider_sub_compare #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .a      (pp),
    .b      ({1'b0, wmag}),
    .diff   (diff),
    .borrow (borrow)
  );

  // Restoring step: keep the shifted value when the subtract borrows.
  assign p_nx = borrow ? pp : diff;
  assign q_nx = {qw[MW-2:0], ~borrow};

  // Remainder stays below the divisor, so the top bit is always clear.
  assign unused_msb = p_nx[WIDTH-1];

  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = bad ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      p    <= '0;
      zlo  <= '0;
      wmag <= '0;
      qw   <= '0;
      cnt  <= '0;
      sq   <= 1'b0;
      sr   <= 1'b0;
      Q    <= '0;
      R    <= '0;
      err  <= 1'b0;
    end else if (accept) begin
      p    <= z_hi[MW-1:0];
      zlo  <= Z[MW-1:0];
      wmag <= w_in;
      qw   <= '0;
      cnt  <= '0;
      sq   <= Z[2*WIDTH-1] ^ W[WIDTH-1];
      sr   <= Z[2*WIDTH-1];
      err  <= bad;
      if (bad) begin
        Q <= '0;
        R <= '0;
      end
    end else if (state == RUN) begin
      p   <= p_nx[MW-1:0];
      zlo <= {zlo[MW-2:0], 1'b0};
      qw  <= q_nx;
      cnt <= cnt + 1'b1;
      if (last) begin
        Q <= {sm_sign(sq, |q_nx), q_nx};
        R <= {sm_sign(sr, |p_nx[MW-1:0]), p_nx[MW-1:0]};
      end
    end
  end

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider.
// Directed cases plus random operands vs arithmetic model.
module tb_shift_sub_divider;

  logic        clk;
  logic        nrst;
  logic        start;
  logic [15:0] Z;
  logic [7:0]  W;
  logic [7:0]  Q;
  logic [7:0]  R;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  shift_sub_divider #(
    .WIDTH (8)
  ) dut (
    .clk   (clk),
    .nrst  (nrst),
    .start (start),
    .Z     (Z),
    .W     (W),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Plain integer division on the magnitudes.
  task automatic model(
    input  logic [15:0] z,
    input  logic [7:0]  w,
    output logic [7:0]  q,
    output logic [7:0]  r,
    output logic        e
  );
    int zm, wm, qm, rm;
    zm = int'(z[14:0]);
    wm = int'(w[6:0]);
    e  = (wm == 0) || ((zm / 128) >= wm);
    if (e) begin
      q = 8'h00;
      r = 8'h00;
    end else begin
      qm = zm / wm;
      rm = zm % wm;
      q  = {(z[15] ^ w[7]) && (qm != 0), 7'(qm)};
      r  = {z[15] && (rm != 0), 7'(rm)};
    end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({tag, ":timeout"}, 32'(n < 20), 32'd1);
  endtask

  task automatic run_div(
    input string       tag,
    input logic [15:0] z,
    input logic [7:0]  w
  );
    logic [7:0] eq, er;
    logic       ee;
    int         k;
    model(z, w, eq, er, ee);
    @(negedge clk);
    start = 1'b1;
    Z     = z;
    W     = w;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
    Z     = 16'($urandom);
    W     = 8'($urandom);
    check({tag, ":busy_k"}, 32'(busy), 32'(!ee));
    check({tag, ":done_k"}, 32'(done), 32'(ee));
    wait_done(tag);
    check({tag, ":lat"}, 32'(cyc - k), ee ? 32'd0 : 32'd7);
    check({tag, ":Q"}, 32'(Q), 32'(eq));
    check({tag, ":R"}, 32'(R), 32'(er));
    check({tag, ":err"}, 32'(err), 32'(ee));
    @(posedge clk);
    #1;
    check({tag, ":done_end"}, 32'(done), 32'd0);
    check({tag, ":busy_end"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int          k;
    logic [6:0]  wm;
    logic [14:0] zm;
    logic [15:0] rz;
    logic [7:0]  rw;

    nrst  = 1'b0;
    start = 1'b0;
    Z     = '0;
    W     = '0;

    repeat (2) @(posedge clk);
    #1;
    check("rst:Q", 32'(Q), 32'h00);
    check("rst:R", 32'(R), 32'h00);
    check("rst:busy", 32'(busy), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:err", 32'(err), 32'd0);

    @(negedge clk);
    nrst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("idle:done", 32'(done), 32'd0);
      check("idle:busy", 32'(busy), 32'd0);
    end

    run_div("basic", 16'h0064, 8'h07);
    check("basic:Qc", 32'(Q), 32'h0E);
    check("basic:Rc", 32'(R), 32'h02);
    run_div("negz", 16'h8064, 8'h07);
    check("negz:Qc", 32'(Q), 32'h8E);
    check("negz:Rc", 32'(R), 32'h82);
    run_div("negzw", 16'h8064, 8'h87);
    check("negzw:Qc", 32'(Q), 32'h0E);
    run_div("qzero", 16'h8005, 8'h07);
    check("qzero:Qc", 32'(Q), 32'h00);
    check("qzero:Rc", 32'(R), 32'h85);
    run_div("div0", 16'h0064, 8'h80);
    check("div0:errc", 32'(err), 32'd1);
    run_div("ovf", 16'h3F80, 8'h7F);
    check("ovf:errc", 32'(err), 32'd1);
    run_div("maxq", 16'h3F7F, 8'h7F);
    check("maxq:Qc", 32'(Q), 32'h7F);
    check("maxq:Rc", 32'(R), 32'h7E);

    // Second start while running must be ignored.
    @(negedge clk);
    start = 1'b1;
    Z     = 16'h0064;
    W     = 8'h07;
    @(posedge clk);
    #1;
    k     = cyc;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    Z     = 16'h1234;
    W     = 8'h11;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("hs");
    check("hs:lat", 32'(cyc - k), 32'd7);
    check("hs:Q", 32'(Q), 32'h0E);
    check("hs:R", 32'(R), 32'h02);
    @(posedge clk);
    #1;
    check("hs:busy_end", 32'(busy), 32'd0);
    run_div("hs_next", 16'h0200, 8'h05);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    start = 1'b1;
    Z     = 16'h0064;
    W     = 8'h09;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("arst:busy_pre", 32'(busy), 32'd1);
    nrst = 1'b0;
    #1;
    check("arst:busy", 32'(busy), 32'd0);
    check("arst:Q", 32'(Q), 32'h00);
    check("arst:R", 32'(R), 32'h00);
    check("arst:done", 32'(done), 32'd0);
    @(negedge clk);
    nrst = 1'b1;
    @(posedge clk);
    #1;
    check("arst:idle", 32'(busy), 32'd0);
    run_div("arst_after", 16'h0064, 8'h07);

    // Random operands, mostly in the non-overflow range.
    for (int i = 0; i < 40; i++) begin
      if (i % 8 == 7) begin
        rz = 16'($urandom);
        rw = 8'($urandom);
      end else begin
        wm = 7'($urandom_range(1, 127));
        zm = 15'($urandom_range(0, int'(wm) * 128 - 1));
        rz = {1'($urandom), zm};
        rw = {1'($urandom), wm};
      end
      run_div("rand", rz, rw);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
